// File: rtl/inst_mem_burst_if.sv
// Refill bus: cache miss port on one side, synchronous instruction ROM on the other.
interface inst_mem_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_enable;
    logic [DATA_WIDTH-1:0] mem_read;
    logic                  mem_read_valid;
    logic                  mem_last;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_en;
    logic [DATA_WIDTH-1:0] rom_data;

    modport master (
        output mem_addr, mem_enable, rom_data,
        input  mem_read, mem_read_valid, mem_last, busy, rom_addr, rom_en
    );

    modport slave (
        input  mem_addr, mem_enable, rom_data,
        output mem_read, mem_read_valid, mem_last, busy, rom_addr, rom_en
    );
endinterface

// File: rtl/inst_mem_burst.sv
// Block refill engine: streams one aligned block from a synchronous ROM, one word per cycle.
//   state | meaning
//   IDLE  | waiting for mem_enable
//   ISSUE | strobing rom_en, one offset per cycle
//   DRAIN | all reads issued, waiting for the last word to return
//   DONE  | block delivered, waiting for mem_enable to drop
module inst_mem_burst #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 16,
    parameter int BLOCK_OFFSET_WIDTH = 5,
    parameter int READ_LATENCY       = 1
) (
    input logic              clk,
    input logic              rst,
    inst_mem_burst_if.slave  bus
);
    localparam int BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH;
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_OFFSET = BLOCK_OFFSET_WIDTH'(BLOCK_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                        state, state_nxt;
    logic [ADDR_WIDTH-1:0]         base;
    logic [BLOCK_OFFSET_WIDTH-1:0] issue_cnt;
    logic [BLOCK_OFFSET_WIDTH-1:0] ret_cnt;
    logic [READ_LATENCY-1:0]       vpipe;
    logic                          start;
    logic                          flush;
    logic                          rom_en_c;
    logic                          rd_valid;
    logic                          last;

    assign rd_valid = vpipe[READ_LATENCY-1];
    assign last     = rd_valid && (ret_cnt == LAST_OFFSET);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // rom_en is gated by mem_enable so an abort stops strobing in the same cycle
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        flush     = 1'b0;
        rom_en_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_enable) begin
                    state_nxt = ISSUE;
                    start     = 1'b1;
                end
            end
            ISSUE: begin
                if (!bus.mem_enable) begin
                    state_nxt = IDLE;
                    flush     = 1'b1;
                end else begin
                    rom_en_c = 1'b1;
                    if (issue_cnt == LAST_OFFSET) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.mem_enable) begin
                    state_nxt = IDLE;
                    flush     = 1'b1;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!bus.mem_enable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            vpipe     <= '0;
        end else begin
            if (start) begin
                base      <= bus.mem_addr & ~OFFSET_MASK;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if (rom_en_c) issue_cnt <= issue_cnt + 1'b1;
                if (rd_valid) ret_cnt   <= ret_cnt + 1'b1;
            end
            if (flush) begin
                vpipe <= '0;
            end else begin
                vpipe[0] <= rom_en_c;
                for (int i = 1; i < READ_LATENCY; i++) vpipe[i] <= vpipe[i-1];
            end
        end
    end

    assign bus.rom_en         = rom_en_c;
    assign bus.rom_addr       = rom_en_c ? (base | {{(ADDR_WIDTH-BLOCK_OFFSET_WIDTH){1'b0}}, issue_cnt}) : '0;
    assign bus.mem_read_valid = rd_valid;
    assign bus.mem_read       = rd_valid ? bus.rom_data : '0;
    assign bus.mem_last       = last;
    assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_inst_mem_burst.sv
// Bench for inst_mem_burst: four instances (READ_LATENCY 1..4) each with its own ROM model.
module tb_inst_mem_burst;
    localparam int BS = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en    [4];
    logic [15:0] addr  [4];
    logic [31:0] rd    [4];
    logic        rv    [4];
    logic        lst   [4];
    logic        bsy   [4];
    logic        ren   [4];
    logic [15:0] raddr [4];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A3C_96E1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        inst_mem_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();
        logic [31:0] pipe [g+1];

        // ROM returns its word g+1 cycles after the strobe; junk otherwise
        always_ff @(posedge clk) begin
            pipe[0] <= bus.rom_en ? rom_word(bus.rom_addr) : $urandom;
            for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
        end

        assign bus.mem_addr   = addr[g];
        assign bus.mem_enable = en[g];
        assign bus.rom_data   = pipe[g];
        assign rd[g]    = bus.mem_read;
        assign rv[g]    = bus.mem_read_valid;
        assign lst[g]   = bus.mem_last;
        assign bsy[g]   = bus.busy;
        assign ren[g]   = bus.rom_en;
        assign raddr[g] = bus.rom_addr;

        inst_mem_burst #(
            .DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5), .READ_LATENCY(g + 1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(input int ln, input string tag);
        chk({tag, " rom_en"}, 32'(ren[ln]), 0);
        chk({tag, " valid"},  32'(rv[ln]),  0);
        chk({tag, " last"},   32'(lst[ln]), 0);
        chk({tag, " busy"},   32'(bsy[ln]), 0);
    endtask

    task automatic check_zero(input int ln, input string tag);
        check_quiet(ln, tag);
        chk({tag, " rom_addr"}, 32'(raddr[ln]), 0);
        chk({tag, " data"},     rd[ln],         0);
    endtask

    // One request on lane ln; abort_k drops enable and rst_k pulses reset in that cycle after the request edge
    task automatic burst(input int ln, input logic [15:0] a, input int abort_k, input int rst_k, input int hold);
        int lat, kend, idx;
        logic [15:0] base;
        logic exp_ren, exp_v;
        lat  = ln + 1;
        kend = BS + lat;
        base = a & 16'hFFE0;
        addr[ln] = a;
        en[ln]   = 1'b1;
        tick();
        for (int k = 1; k <= kend; k++) begin
            addr[ln] = 16'($urandom);
            if (k == rst_k) begin
                rst    = 1'b1;
                en[ln] = 1'b0;
                tick();
                rst = 1'b0;
                #1;
                check_zero(ln, "after_rst");
                for (int j = 0; j < 4; j++) begin
                    tick(); #1;
                    check_zero(ln, "post_rst");
                end
                return;
            end
            if (k == abort_k) en[ln] = 1'b0;
            #1;
            idx     = k - lat - 1;
            exp_ren = (k <= BS) && (k != abort_k);
            exp_v   = (idx >= 0) && (idx < BS);
            chk("rom_en", 32'(ren[ln]), 32'(exp_ren));
            if (exp_ren) chk("rom_addr", 32'(raddr[ln]), 32'(base + 16'(k - 1)));
            chk("valid", 32'(rv[ln]), 32'(exp_v));
            chk("data", rd[ln], exp_v ? rom_word(base + 16'(idx)) : 32'd0);
            chk("last", 32'(lst[ln]), 32'(exp_v && idx == BS - 1));
            chk("busy", 32'(bsy[ln]), 1);
            if (k == abort_k) begin
                for (int j = 0; j < 4; j++) begin
                    tick(); #1;
                    check_quiet(ln, "post_abort");
                end
                return;
            end
            tick();
        end
        for (int h = 0; h < hold; h++) begin
            #1;
            chk("done rom_en", 32'(ren[ln]), 0);
            chk("done valid",  32'(rv[ln]),  0);
            chk("done busy",   32'(bsy[ln]), 1);
            tick();
        end
        en[ln] = 1'b0;
        #1;
        chk("done_drop busy", 32'(bsy[ln]), 1);
        chk("done_drop rom_en", 32'(ren[ln]), 0);
        tick(); #1;
        check_quiet(ln, "back_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en[i]   = 1'b0;
            addr[i] = 16'($urandom);
        end
        tick(); tick();
        #1;
        for (int i = 0; i < 4; i++) check_zero(i, "reset");
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(); #1;
            for (int i = 0; i < 4; i++) check_quiet(i, "idle");
        end

        burst(0, 16'h1234, 0, 0, 0);
        burst(2, 16'hFFE5, 0, 0, 0);
        burst(0, 16'($urandom), 0, 0, 3);
        burst(0, 16'($urandom), 0, 0, 0);
        burst(1, 16'($urandom), 11, 0, 0);
        burst(1, 16'($urandom), 0, 0, 1);
        burst(3, 16'($urandom), 0, 34, 0);
        burst(3, 16'($urandom), 0, 0, 0);
        for (int r = 0; r < 4; r++)
            burst(r, 16'($urandom), 0, 0, int'($urandom_range(0, 2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
